axa_undo_buffer: RTL
====================

# axa_undo_buffer

Parametrised circular undo stack for the reversible AXA pipeline. Forward execution pushes pre-write register values (and `land` return PCs); reverse execution pops them to restore destinations. It also serves relative-offset reads for `ILTypeUnd` source operands. It generalises the fixed 16-entry, 16-bit in-core stack with configurable width and depth, occupancy tracking, explicit overflow/underflow signalling, and a commit operation that discards the undo history.

## Interface
- `WIDTH`, 16: data word width in bits.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `PW`, $clog2(DEPTH): pointer/offset width (derived, not overridden).
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `push_valid`  in  1  push `push_data` this cycle.
- `push_data`  in  WIDTH  value to save.
- `pop_valid`  in  1  pop top entry this cycle (reverse-execution restore).
- `commit`  in  1  discard all undoable entries (`com`).
- `clear_errs`  in  1  clear the sticky `lost` and `underflow` flags.
- `peek_off`  in  PW  offset from top; 0 = most recent entry.
- `peek_data`  out  WIDTH  combinational read of `mem[sp - peek_off - 1]` (mod DEPTH).
- `pop_data`  out  WIDTH  registered popped value.
- `pop_data_valid`  out  1  high for one cycle after an accepted pop.
- `count`  out  PW+1  valid undoable entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `lost`  out  1  sticky: an undoable entry was overwritten by a push while full.
- `underflow`  out  1  sticky: a pop arrived while empty.

## Operation
- State: `sp` (PW bits, wraps mod DEPTH; next write slot), `count`, storage `mem[DEPTH]`, and the two sticky flags.
- Evaluation order within one cycle, all against pre-cycle state: pop, then commit, then push.
- Push only: `mem[sp] <= push_data`; `sp <= sp+1`. If `count < DEPTH`, `count++`. If full, `count` stays DEPTH, the oldest entry is overwritten, and `lost <= 1`.
- Pop only, not empty: `pop_data <= mem[sp-1]`; `pop_data_valid <= 1`; `sp <= sp-1`; `count--`.
- Pop only, empty: `underflow <= 1`; `pop_data_valid <= 0`; `sp`, `count` and `pop_data` unchanged.
- Push + pop, not empty: `pop_data <= mem[sp-1]`, valid; `mem[sp-1] <= push_data` (top replaced); `sp` and `count` unchanged. `lost` is not set, even when full.
- Push + pop, empty: `underflow` set; push proceeds as push only.
- Commit: `count <= 0`; `sp` and `mem` are untouched. With pop in the same cycle, the pop is serviced first, then `count` becomes 0. With push in the same cycle, `count` ends at 1.
- `clear_errs`: both flags go to 0. If a set condition occurs in the same cycle, the set wins.
- `peek_data` does not depend on `count`. Offsets ≥ `count` return stale data without any error; the decoder must range-check.
- Reset mid-operation drops all state. A pop issued in the reset cycle produces no `pop_data_valid`.

## Timing
- Reset values: `sp=0`, `count=0`, `empty=1`, `full=0`, `lost=0`, `underflow=0`, `pop_data=0`, `pop_data_valid=0`. `mem` is not reset.
- Pop latency is 1 cycle: `pop_valid` in cycle N gives `pop_data`/`pop_data_valid` in N+1. `pop_data` holds its value until the next accepted pop.
- A push in cycle N is visible on `peek_data` (offset 0) from N+1. There is no same-cycle bypass.
- `count`, `empty`, `full` and the flags are registered and update at the edge ending the request cycle.
- There is no backpressure: every request is accepted in the cycle it is presented.

## Structure
- Shared `axa_pkg`: `WORD` width default, `UPTR` derivation helper, and the `ILTypeUnd` encoding used by callers.
- Sub-module `axa_undo_ram`: DEPTH×WIDTH storage with 1 synchronous write port, 1 synchronous read port (pop) and 1 asynchronous read port (peek). The top level holds the pointer, count and flag logic.

## Test plan
- Reset, push 0x1111, 0x2222, 0x3333 -> `count=3`; `peek_off=0` gives 0x3333 and `peek_off=2` gives 0x1111; three pops return 0x3333, 0x2222, 0x1111, each valid 1 cycle later; `empty=1`.
- DEPTH=4: push 1..5 -> `full=1`, `lost=1`, `count=4`; pops return 5, 4, 3, 2; a fifth pop sets `underflow`, no valid pulse.
- Push 0xAAAA, then push 0xBBBB with pop in the same cycle -> `pop_data=0xAAAA`, `count=1`, `peek_off=0` gives 0xBBBB; with `full=1`, `lost` stays 0.
- Push 0x10, 0x20; commit + push 0x30 in the same cycle -> `count=1`; pop returns 0x30; next pop sets `underflow`.
- Pointer wrap with DEPTH=4: 6 pushes/5 pops interleaved -> `sp` wraps through 0 and `peek_data` stays correct; `clear_errs` clears the flags; asserting reset mid-burst gives all outputs at their reset values and no `pop_data_valid`.

Source files
------------

// File: rtl/axa_pkg.sv
// Shared AXA definitions: default word width, pointer-width helper and instruction
// type encodings used by the undo-stack callers.
package axa_pkg;

    localparam int WORD = 16;

    typedef enum logic [1:0] {
        ILTypeR   = 2'd0,
        ILTypeI   = 2'd1,
        ILTypeJ   = 2'd2,
        ILTypeUnd = 2'd3
    } il_type_e;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int uptr(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axa_undo_ram.sv
// Undo-stack storage: one synchronous write, one registered read (pop) and one
// asynchronous read (peek). Read register resets to zero; the array does not.
module axa_undo_ram
    import axa_pkg::*;
#(
    parameter  int WIDTH = WORD,
    parameter  int DEPTH = 16,
    localparam int PW    = uptr(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [PW-1:0]    paddr,
    output logic [WIDTH-1:0] pdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a pop and a top-replacing push to the same slot return the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
    assign pdata = mem[paddr];

endmodule

// File: rtl/axa_undo_buffer.sv
// Circular undo stack: push saves pre-write values, pop restores them (1-cycle latency),
// commit discards history. Every request is accepted; overflow/underflow are sticky flags.
module axa_undo_buffer
    import axa_pkg::*;
#(
    parameter  int WIDTH = WORD,
    parameter  int DEPTH = 16,
    localparam int PW    = uptr(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_valid,
    input  logic             commit,
    input  logic             clear_errs,
    input  logic [PW-1:0]    peek_off,
    output logic [WIDTH-1:0] peek_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_data_valid,
    output logic [PW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             lost,
    output logic             underflow
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] sp_q, sp_d;
    logic [PW:0]   count_q, count_d, cnt_after_pop, cnt_after_com;
    logic          lost_q, lost_d, underflow_q, underflow_d, pdv_q;
    logic          pop_ok, pop_err, lost_set;
    logic [PW-1:0] top_idx, waddr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop_valid && !empty;
    assign pop_err = pop_valid && empty;
    assign top_idx = sp_q - PW'(1);

    // A push alongside a serviced pop replaces the top rather than advancing.
    assign waddr    = (push_valid && pop_ok) ? top_idx : sp_q;
    assign lost_set = push_valid && !pop_ok && !commit && full;

    always_comb begin
        sp_d = sp_q;
        if (pop_ok && !push_valid) begin
            sp_d = sp_q - PW'(1);
        end else if (push_valid && !pop_ok) begin
            sp_d = sp_q + PW'(1);
        end

        cnt_after_pop = pop_ok ? (count_q - (PW+1)'(1)) : count_q;
        cnt_after_com = commit ? '0 : cnt_after_pop;
        count_d       = cnt_after_com;
        if (push_valid && (cnt_after_com != FULL_CNT)) begin
            count_d = cnt_after_com + (PW+1)'(1);
        end

        lost_d      = lost_set || (lost_q && !clear_errs);
        underflow_d = pop_err || (underflow_q && !clear_errs);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= '0;
            count_q     <= '0;
            lost_q      <= 1'b0;
            underflow_q <= 1'b0;
            pdv_q       <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            lost_q      <= lost_d;
            underflow_q <= underflow_d;
            pdv_q       <= pop_ok;
        end
    end

    axa_undo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push_valid && !reset),
        .waddr (waddr),
        .wdata (push_data),
        .re    (pop_ok),
        .raddr (top_idx),
        .rdata (pop_data),
        .paddr (sp_q - peek_off - PW'(1)),
        .pdata (peek_data)
    );

    assign count          = count_q;
    assign pop_data_valid = pdv_q;
    assign lost           = lost_q;
    assign underflow      = underflow_q;

endmodule
